max_selector_tree: RTL
======================

Name: max_selector_tree

Overview:
- Pipelined N-way maximum selector over CHANNELS (value, discriminant) pairs.
- Returns the pair with the largest discriminant, plus the index of its source channel.
- Registered binary reduction tree with a valid/ready stream interface on input and output.
- Sits between the per-channel candidate generators and the downstream scheduler or consumer, replacing cascades of two-input combinational selectors.

Parameters:
- CHANNELS, 8, number of input pairs; any integer ≥ 2; the tree is padded internally to the next power of two with invalid leaves.
- VALUE_SIZE, 4, width of each value field in bits.
- DISCRIMINANT_SIZE, 4, width of each discriminant field in bits, compared as unsigned.
- INDEX_SIZE, $clog2(CHANNELS), width of the winner index output.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  input vector valid.
- in_ready  output  1  block accepts the vector this cycle.
- in_mask  input  CHANNELS  per-channel participation; bit i=0 excludes channel i.
- in_values  input  CHANNELS*VALUE_SIZE  packed values; channel i at [i*VALUE_SIZE +: VALUE_SIZE].
- in_discriminants  input  CHANNELS*DISCRIMINANT_SIZE  packed discriminants, same packing rule.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_found  output  1  at least one masked-in channel existed.
- out_value  output  VALUE_SIZE  winning value.
- out_discriminant  output  DISCRIMINANT_SIZE  winning discriminant.
- out_index  output  INDEX_SIZE  winning channel index.

Behaviour:
- Interface (already decided): one clock, "clock"; reset "reset" is asynchronous and active-high.
- Tree structure:
  - STAGES = $clog2(CHANNELS) register stages.
  - Each stage registers (found, value, discriminant, index) per node, plus one stage-valid bit.
- Node rule, left = lower index, right = higher index:
  - Only one side found: that side wins.
  - Both found: left wins only if disc_left > disc_right (strict); otherwise right wins.
  - Neither found: node found=0; value, discriminant and index are 0.
  - Net effect: ties resolve to the highest channel index.
  - found propagates as the OR of both children.
- Handshake:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall, combinational.
  - When ~stall, every stage shifts forward one position. Stage 0 captures in_valid and the input data; a stage-valid of 0 creates a bubble.
  - When stall, all stages hold their contents.
  - An input transfer occurs iff in_valid & in_ready; an output transfer occurs iff out_valid & out_ready.
- Timing:
  - Latency is STAGES cycles from input transfer to out_valid with no stalls.
  - Throughput is one vector per cycle.
  - Outputs are driven directly from the last stage registers.
- Data stability: out_* is stable while out_valid & ~out_ready. Input data is sampled only on transfer.
- Reset, at any time including mid-pipeline:
  - All stage-valid bits clear, discarding in-flight vectors.
  - out_valid=0, out_found=0, out_value=0, out_discriminant=0, out_index=0.
  - in_ready=1 from the first cycle after reset deasserts.
- Empty vector: in_mask all zero still produces a result with out_valid=1, out_found=0 and zero data.
- Discriminant bounds: all-ones and all-zero discriminants are legal. A masked-in channel with discriminant 0 beats any masked-out channel.
- Simultaneous events: an output transfer and an input transfer in the same cycle is normal pipeline advance; nothing is lost or duplicated.

Optional Feature:
- Macro: MAX_SELECTOR_TREE_MIN_MODE_EN.
- Defined:
  - Each node selects the smallest discriminant: left wins iff disc_left < disc_right.
  - Ties still resolve to the highest index.
  - Masking, handshake and latency are unchanged.
- Undefined: maximum selection as specified above.

Test Plan:
- CHANNELS=8, mask=0xFF, discriminants {3,9,1,7,2,0,5,4}, values = index+8, out_ready=1 -> after 3 cycles: out_valid=1, found=1, disc=9, value=9, index=1.
- All discriminants =6, mask=0xFF -> index=7, disc=6 (tie goes to highest). With mask=0x0F -> index=3.
- mask=0x00 -> out_valid=1 after 3 cycles, found=0, value=0, disc=0, index=0. Then mask=0x20 with disc[5]=0 -> found=1, index=5.
- Back-to-back stream of 10 random vectors with out_ready toggling every 2 cycles:
  - Results match a reference model in order, with none dropped or duplicated.
  - in_ready=0 exactly when out_valid & ~out_ready.
  - out_* is held stable during the stall.
- Assert reset for 1 cycle while 3 vectors are in flight -> out_valid=0 and all outputs 0 immediately. The next vector after reset is the first result, after 3 cycles.
- CHANNELS=5: disc {2,2,8,8,1} -> index=3. Same vector with MAX_SELECTOR_TREE_MIN_MODE_EN defined -> disc=1, index=4.

Source files
------------

// File: rtl/max_selector_tree.sv
// rtl/max_selector_tree.sv - pipelined N-way max (or min) selector over (value, discriminant) pairs
// Optional feature: define MAX_SELECTOR_TREE_MIN_MODE_EN to select the smallest discriminant instead.
module max_selector_tree #(
  parameter int CHANNELS          = 8,
  parameter int VALUE_SIZE        = 4,
  parameter int DISCRIMINANT_SIZE = 4,
  parameter int INDEX_SIZE        = $clog2(CHANNELS)
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [CHANNELS-1:0]                   in_mask,
  input  logic [CHANNELS*VALUE_SIZE-1:0]        in_values,
  input  logic [CHANNELS*DISCRIMINANT_SIZE-1:0] in_discriminants,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic                                  out_found,
  output logic [VALUE_SIZE-1:0]                 out_value,
  output logic [DISCRIMINANT_SIZE-1:0]          out_discriminant,
  output logic [INDEX_SIZE-1:0]                 out_index
);

  localparam int STAGES = $clog2(CHANNELS);
  localparam int LEAVES = 1 << STAGES;
  localparam int TREE   = 2 * LEAVES - 1;

  typedef struct packed {
    logic                         found;
    logic [VALUE_SIZE-1:0]        value;
    logic [DISCRIMINANT_SIZE-1:0] disc;
    logic [INDEX_SIZE-1:0]        index;
  } node_t;

  // Right (higher index) wins unless left is strictly better, so ties go to the highest channel.
  function automatic node_t f_pick(input node_t a_l, input node_t a_r);
    node_t v_res;
    logic  v_left;
    v_res = '0;
`ifdef MAX_SELECTOR_TREE_MIN_MODE_EN
    v_left = a_l.disc < a_r.disc;
`else
    v_left = a_l.disc > a_r.disc;
`endif
    if (a_l.found && a_r.found) begin
      v_res = v_left ? a_l : a_r;
    end else if (a_l.found) begin
      v_res = a_l;
    end else if (a_r.found) begin
      v_res = a_r;
    end
    return v_res;
  endfunction

  // Flat tree: entries [0, LEAVES) are the input leaves, then each stage's registered nodes in order.
  node_t             w_tree [TREE];
  logic [STAGES:0]   w_stage_valid;
  logic              w_stall;
  node_t             w_root;

  assign w_stage_valid[0] = in_valid;

  for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
    if (i < CHANNELS) begin : g_real
      assign w_tree[i] = '{found: in_mask[i],
                           value: in_values[i*VALUE_SIZE +: VALUE_SIZE],
                           disc:  in_discriminants[i*DISCRIMINANT_SIZE +: DISCRIMINANT_SIZE],
                           index: INDEX_SIZE'(i)};
    end else begin : g_pad
      assign w_tree[i] = '0;
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int NODES    = LEAVES >> (s + 1);
    localparam int IN_BASE  = 2 * LEAVES - ((2 * LEAVES) >> s);
    localparam int OUT_BASE = 2 * LEAVES - (LEAVES >> s);

    node_t r_node [NODES];
    logic  r_valid;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        r_valid <= 1'b0;
        for (int n = 0; n < NODES; n++) begin
          r_node[n] <= '0;
        end
      end else if (!w_stall) begin
        r_valid <= w_stage_valid[s];
        if (w_stage_valid[s]) begin
          for (int n = 0; n < NODES; n++) begin
            r_node[n] <= f_pick(w_tree[IN_BASE + 2*n], w_tree[IN_BASE + 2*n + 1]);
          end
        end
      end
    end

    assign w_stage_valid[s+1] = r_valid;

    for (genvar n = 0; n < NODES; n++) begin : g_out
      assign w_tree[OUT_BASE + n] = r_node[n];
    end
  end

  assign w_root           = w_tree[TREE-1];
  assign out_valid        = w_stage_valid[STAGES];
  assign w_stall          = out_valid & ~out_ready;
  assign in_ready         = ~w_stall;
  assign out_found        = w_root.found;
  assign out_value        = w_root.value;
  assign out_discriminant = w_root.disc;
  assign out_index        = w_root.index;

endmodule
